// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO in front of a start/data/parity/stop framer.
// tx, busy and done are registered, so the line lags the framer state by one cycle.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 1250,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 data_valid,
  input  logic [DATA_BITS-1:0] data,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [CntW-1:0] CntMax   = CntW'(CLKS_PER_BIT - 1);
  localparam logic [PtrW:0]   Depth    = (PtrW + 1)'(FIFO_DEPTH);
  localparam logic [3:0]      DataLast = 4'(DATA_BITS - 1);
  localparam logic [3:0]      StopLast = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } state_e;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]        count_q, count_d;
  state_e               state_q, state_d;
  logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 frame_end_q, frame_end_d;
  logic                 done_q;
  logic                 push, pop, fifo_empty, bit_end;

  assign ready      = count_q < Depth;
  assign push       = data_valid && ready && !reset;
  assign fifo_empty = (count_q == '0);
  assign bit_end    = (bit_cnt_q == CntMax);

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      frame_end_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      count_q     <= count_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      frame_end_q <= frame_end_d;
      done_q      <= frame_end_q;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data;
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_end ? '0 : bit_cnt_q + 1'b1;
    idx_d       = idx_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    pop         = 1'b0;
    frame_end_d = 1'b0;
    case (state_q)
      StIdle: begin
        bit_cnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          idx_d   = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == DataLast) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? StParity : StStop;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      StParity: begin
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        if (bit_end) begin
          if (idx_q == StopLast) begin
            frame_end_d = 1'b1;
            idx_d       = '0;
            // Chain straight into the next frame when a word is waiting.
            if (!fifo_empty) begin
              pop     = 1'b1;
              state_d = StStart;
            end else begin
              state_d = StIdle;
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: begin
        state_d   = StIdle;
        bit_cnt_d = '0;
        idx_d     = '0;
      end
    endcase
    if (pop) begin
      shift_d  = mem_q[rd_ptr_q];
      parity_d = (^mem_q[rd_ptr_q]) ^ (PARITY == 2);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    busy_d = (state_q != StIdle) || !fifo_empty;
    case (state_q)
      StIdle:   tx_d = 1'b1;
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_q[0];
      StParity: tx_d = parity_q;
      StStop:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three parameterisations, expected frames queued at write time
// and checked bit-by-bit on the serial line by an independent monitor.
module tb_uart_tx_fifo;

  localparam int CPB = 4;

  typedef struct {
    logic [15:0] bits;
    int          len;
    bit          gap0;
  } frame_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid;
  logic [7:0] data;
  int         sel;

  logic va, vb, vc;
  logic ready_a, tx_a, busy_a, done_a;
  logic ready_b, tx_b, busy_b, done_b;
  logic ready_c, tx_c, busy_c, done_c;
  logic m_tx, m_busy, m_done;

  frame_t      exp_q[$];
  frame_t      cur;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en;
  bit          in_frame = 1'b0;
  bit          exp_done_next = 1'b0;
  bit          bad;
  bit          done_seen;
  int          idle_cnt = 0;
  int          j;
  int          bi;
  logic [15:0] got;

  always #5 clk = ~clk;

  assign va = valid && (sel == 0);
  assign vb = valid && (sel == 1);
  assign vc = valid && (sel == 2);
  assign m_tx   = (sel == 0) ? tx_a   : (sel == 1) ? tx_b   : tx_c;
  assign m_busy = (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
  assign m_done = (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB)) dut_a (
    .clk(clk), .reset(reset), .data_valid(va), .data(data),
    .ready(ready_a), .tx(tx_a), .busy(busy_a), .done(done_a)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset(reset), .data_valid(vb), .data(data[6:0]),
    .ready(ready_b), .tx(tx_b), .busy(busy_b), .done(done_b)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .PARITY(2)) dut_c (
    .clk(clk), .reset(reset), .data_valid(vc), .data(data),
    .ready(ready_c), .tx(tx_c), .busy(busy_c), .done(done_c)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [15:0] bits, input int len, input bit gap0);
    frame_t f;
    f.bits = bits;
    f.len  = len;
    f.gap0 = gap0;
    exp_q.push_back(f);
  endtask

  // Called and returns at a falling edge; data is scrambled right after acceptance.
  task automatic write_word(input logic [7:0] w);
    valid = 1'b1;
    data  = w;
    @(negedge clk);
    valid = 1'b0;
    data  = ~w;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || in_frame || exp_done_next) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d frames still pending after %0d cycles",
               exp_q.size(), budget);
    end
    repeat (3) @(negedge clk);
  endtask

  // Line monitor: every cycle of a frame must match the expected bit, done must pulse
  // on the first cycle after the last stop bit, with busy dropping there for the last frame.
  initial forever begin
    @(negedge clk);
    done_seen = 1'b0;
    if (!mon_en) begin
      in_frame      = 1'b0;
      exp_done_next = 1'b0;
      idle_cnt      = 0;
    end else begin
      if (exp_done_next) begin
        check("done_pulse", 32'(m_done), 32'd1);
        check("busy_after_frame", 32'(m_busy), 32'(exp_q.size() != 0));
        exp_done_next = 1'b0;
        done_seen     = 1'b1;
      end
      if (!in_frame) begin
        if (m_tx === 1'b0) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: tx low at %0t with no frame expected", $time);
            cur.bits = '0;
            cur.len  = 10;
            cur.gap0 = 1'b0;
          end else begin
            cur = exp_q.pop_front();
            if (cur.gap0) check("frame_gap", 32'(idle_cnt), 32'd0);
          end
          in_frame = 1'b1;
          j        = 0;
          bad      = 1'b0;
          got      = '0;
        end else begin
          idle_cnt++;
          if (m_done === 1'b1 && !done_seen) begin
            checks++;
            errors++;
            $display("FAIL stray_done: done high at %0t outside a frame end", $time);
          end
        end
      end
      if (in_frame) begin
        bi = j / CPB;
        if (j % CPB == CPB / 2) got[bi] = m_tx;
        if (m_tx !== cur.bits[bi] || m_busy !== 1'b1 || (j > 0 && m_done !== 1'b0)) bad = 1'b1;
        if (j == cur.len * CPB - 1) begin
          checks++;
          if (bad || got !== cur.bits) begin
            errors++;
            $display("FAIL frame: got %b, expected %b (timing/busy/done fault=%0d)",
                     got, cur.bits, bad);
          end
          in_frame      = 1'b0;
          exp_done_next = 1'b1;
          idle_cnt      = 0;
        end else begin
          j++;
        end
      end
    end
  end

  logic [7:0]  burst_w   [6] = '{8'h01, 8'h80, 8'h3C, 8'hFF, 8'h00, 8'h55};
  logic [15:0] burst_f   [5] = '{16'b10_0000_0010, 16'b11_0000_0000, 16'b10_0111_1000,
                                 16'b11_1111_1110, 16'b10_0000_0000};
  logic        burst_rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  int tx_low_cnt;
  int done_cnt;

  initial begin
    sel    = 0;
    mon_en = 1'b1;
    reset  = 1'b1;
    valid  = 1'b1;
    data   = 8'h5A;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    valid = 1'b0;
    check("rst_tx", 32'(tx_a), 32'd1);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_ready", 32'(ready_a), 32'd1);
    check("rst_ready_b", 32'(ready_b), 32'd1);
    check("rst_tx_c", 32'(tx_c), 32'd1);

    // 8N1 0xA5 with start-latency check; data is changed after acceptance.
    push_exp(16'b11_0100_1010, 10, 1'b0);
    write_word(8'hA5);
    @(negedge clk);
    check("latency_k1_tx", 32'(tx_a), 32'd1);
    @(negedge clk);
    check("latency_k2_tx", 32'(tx_a), 32'd0);
    wait_drain(200);

    // Six writes on consecutive edges: five accepted, sixth dropped, frames back-to-back.
    for (int i = 0; i < 5; i++) push_exp(burst_f[i], 10, i > 0);
    for (int i = 0; i < 6; i++) begin
      valid = 1'b1;
      data  = burst_w[i];
      check("burst_ready", 32'(ready_a), 32'(burst_rdy[i]));
      @(negedge clk);
    end
    valid = 1'b0;
    wait_drain(800);

    // 7 data bits, even parity, two stop bits: 0x53 -> parity 0.
    sel = 1;
    push_exp(16'b110_1010_0110, 11, 1'b0);
    write_word(8'h53);
    wait_drain(300);

    // 8 data bits, odd parity: 0x00 -> 1, 0xFF -> 1, 0x01 -> 0.
    sel = 2;
    push_exp(16'b110_0000_0000, 11, 1'b0);
    push_exp(16'b111_1111_1110, 11, 1'b1);
    push_exp(16'b100_0000_0010, 11, 1'b1);
    valid = 1'b1;
    data  = 8'h00;
    @(negedge clk);
    data = 8'hFF;
    @(negedge clk);
    data = 8'h01;
    @(negedge clk);
    valid = 1'b0;
    wait_drain(600);

    // Reset in the middle of the data bits with two words still queued.
    sel    = 0;
    mon_en = 1'b0;
    valid  = 1'b1;
    data   = 8'h11;
    @(negedge clk);
    data = 8'h22;
    @(negedge clk);
    data = 8'h33;
    @(negedge clk);
    valid = 1'b0;
    repeat (12) @(negedge clk);
    reset = 1'b1;
    valid = 1'b1;
    data  = 8'hC3;
    @(negedge clk);
    reset = 1'b0;
    valid = 1'b0;
    check("abort_tx", 32'(tx_a), 32'd1);
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_ready", 32'(ready_a), 32'd1);
    check("abort_done", 32'(done_a), 32'd0);
    tx_low_cnt = 0;
    done_cnt   = 0;
    repeat (150) begin
      @(negedge clk);
      if (tx_a !== 1'b1) tx_low_cnt++;
      if (done_a !== 1'b0) done_cnt++;
    end
    check("abort_no_frames", 32'(tx_low_cnt), 32'd0);
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_busy_late", 32'(busy_a), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
